// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, EX operand forwarding
// from EX/MEM and MEM/WB, and a saturating count of inserted bubbles.
module id_ex_stage #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             stallIn,
   input  logic             idValid,
   input  logic [4:0]       idRs1,
   input  logic [4:0]       idRs2,
   input  logic [4:0]       idRd,
   input  logic [31:0]      idData1,
   input  logic [31:0]      idData2,
   input  logic [31:0]      idImm,
   input  logic             idAluSrc,
   input  logic [3:0]       idAluOp,
   input  logic [3:0]       idCtrl,
   input  logic             exMemRegWrite,
   input  logic [4:0]       exMemRd,
   input  logic [31:0]      exMemResult,
   input  logic             memWbRegWrite,
   input  logic [4:0]       memWbRd,
   input  logic [31:0]      memWbResult,
   output logic             stallOut,
   output logic             exValid,
   output logic [4:0]       exRd,
   output logic [3:0]       exAluOp,
   output logic [3:0]       exCtrl,
   output logic [31:0]      data1,
   output logic [31:0]      data2,
   output logic [31:0]      imm,
   output logic             aluSrc,
   output logic [CNT_W-1:0] bubbleCount
);

   logic [4:0]  rs1_p1, rs2_p1;
   logic [31:0] raw1_p1, raw2_p1;
   logic        loadUse;
   logic        bubble;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   // Younger producer (EX/MEM) wins; x0 is hardwired zero and never forwards.
   function automatic logic [31:0] fwd(input logic [4:0]  rs,
                                       input logic [31:0] raw,
                                       input logic        emW,
                                       input logic [4:0]  emRd,
                                       input logic [31:0] emRes,
                                       input logic        wbW,
                                       input logic [4:0]  wbRd,
                                       input logic [31:0] wbRes);
      if (emW && (emRd != 5'd0) && (emRd == rs))
         return emRes;
      else if (wbW && (wbRd != 5'd0) && (wbRd == rs))
         return wbRes;
      else
         return raw;
   endfunction

   assign loadUse  = exValid & exCtrl[2] & (exRd != 5'd0) & idValid &
                     ((exRd == idRs1) | (exRd == idRs2));
   assign stallOut = (loadUse & ~flush) | stallIn;
   assign bubble   = loadUse & ~flush & ~stallIn;

   // ID -> EX register boundary
   always_ff @(posedge clk) begin
      if (reset || flush || bubble) begin
         exValid <= 1'b0;
         exCtrl  <= 4'd0;
         exRd    <= 5'd0;
         exAluOp <= 4'd0;
         imm     <= 32'd0;
         aluSrc  <= 1'b0;
         rs1_p1  <= 5'd0;
         rs2_p1  <= 5'd0;
         raw1_p1 <= 32'd0;
         raw2_p1 <= 32'd0;
      end else if (!stallIn) begin
         exValid <= idValid;
         exCtrl  <= idValid ? idCtrl : 4'd0;
         exRd    <= idRd;
         exAluOp <= idAluOp;
         imm     <= idImm;
         aluSrc  <= idAluSrc;
         rs1_p1  <= idRs1;
         rs2_p1  <= idRs2;
         raw1_p1 <= idData1;
         raw2_p1 <= idData2;
      end

      if (reset)
         bubbleCount <= '0;
      else if (bubble)
         bubbleCount <= sat_inc(bubbleCount);
   end

   // EX operand selection from registered indices
   always_comb begin
      data1 = fwd(rs1_p1, raw1_p1, exMemRegWrite, exMemRd, exMemResult,
                  memWbRegWrite, memWbRd, memWbResult);
      data2 = fwd(rs2_p1, raw2_p1, exMemRegWrite, exMemRd, exMemResult,
                  memWbRegWrite, memWbRd, memWbResult);
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard/forwarding scenarios followed by
// randomized traffic, all checked against an instruction-level reference model.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        reset, flush, stallIn, idValid;
   logic [4:0]  idRs1, idRs2, idRd;
   logic [31:0] idData1, idData2, idImm;
   logic        idAluSrc;
   logic [3:0]  idAluOp, idCtrl;
   logic        exMemRegWrite, memWbRegWrite;
   logic [4:0]  exMemRd, memWbRd;
   logic [31:0] exMemResult, memWbResult;

   logic        stallOut, exValid, aluSrc;
   logic [4:0]  exRd;
   logic [3:0]  exAluOp, exCtrl;
   logic [31:0] data1, data2, imm;
   logic [15:0] bubbleCount;

   logic        s_stallOut, s_exValid, s_aluSrc;
   logic [4:0]  s_exRd;
   logic [3:0]  s_exAluOp, s_exCtrl;
   logic [31:0] s_data1, s_data2, s_imm;
   logic [1:0]  s_bubbleCount;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.CNT_W(16)) dut (
      .clk(clk), .reset(reset), .flush(flush), .stallIn(stallIn), .idValid(idValid),
      .idRs1(idRs1), .idRs2(idRs2), .idRd(idRd), .idData1(idData1), .idData2(idData2),
      .idImm(idImm), .idAluSrc(idAluSrc), .idAluOp(idAluOp), .idCtrl(idCtrl),
      .exMemRegWrite(exMemRegWrite), .exMemRd(exMemRd), .exMemResult(exMemResult),
      .memWbRegWrite(memWbRegWrite), .memWbRd(memWbRd), .memWbResult(memWbResult),
      .stallOut(stallOut), .exValid(exValid), .exRd(exRd), .exAluOp(exAluOp),
      .exCtrl(exCtrl), .data1(data1), .data2(data2), .imm(imm), .aluSrc(aluSrc),
      .bubbleCount(bubbleCount));

   id_ex_stage #(.CNT_W(2)) u_sat (
      .clk(clk), .reset(reset), .flush(flush), .stallIn(stallIn), .idValid(idValid),
      .idRs1(idRs1), .idRs2(idRs2), .idRd(idRd), .idData1(idData1), .idData2(idData2),
      .idImm(idImm), .idAluSrc(idAluSrc), .idAluOp(idAluOp), .idCtrl(idCtrl),
      .exMemRegWrite(exMemRegWrite), .exMemRd(exMemRd), .exMemResult(exMemResult),
      .memWbRegWrite(memWbRegWrite), .memWbRd(memWbRd), .memWbResult(memWbResult),
      .stallOut(s_stallOut), .exValid(s_exValid), .exRd(s_exRd), .exAluOp(s_exAluOp),
      .exCtrl(s_exCtrl), .data1(s_data1), .data2(s_data2), .imm(s_imm), .aluSrc(s_aluSrc),
      .bubbleCount(s_bubbleCount));

   // Reference model: the instruction sitting in EX, plus a plain bubble tally.
   typedef struct {
      bit        v;
      bit [4:0]  rd, rs1, rs2;
      bit [3:0]  op, ctrl;
      bit [31:0] imm, d1, d2;
      bit        src;
   } slot_t;

   slot_t m;
   int    bubbles;

   function automatic slot_t empty_slot();
      slot_t s;
      s.v = 0; s.rd = 0; s.rs1 = 0; s.rs2 = 0; s.op = 0; s.ctrl = 0;
      s.imm = 0; s.d1 = 0; s.d2 = 0; s.src = 0;
      return s;
   endfunction

   function automatic bit [31:0] fwd_exp(input bit [4:0] r, input bit [31:0] raw);
      if (r != 0 && exMemRegWrite && exMemRd == r) return exMemResult;
      if (r != 0 && memWbRegWrite && memWbRd == r) return memWbResult;
      return raw;
   endfunction

   function automatic bit load_use_exp();
      return m.v && m.ctrl[2] && m.rd != 0 && idValid && (m.rd == idRs1 || m.rd == idRs2);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      chk("exValid", 32'(exValid), 32'(m.v));
      chk("exRd", 32'(exRd), 32'(m.rd));
      chk("exAluOp", 32'(exAluOp), 32'(m.op));
      chk("exCtrl", 32'(exCtrl), 32'(m.ctrl));
      chk("imm", imm, m.imm);
      chk("aluSrc", 32'(aluSrc), 32'(m.src));
      chk("data1", data1, fwd_exp(m.rs1, m.d1));
      chk("data2", data2, fwd_exp(m.rs2, m.d2));
      chk("bubbleCount", 32'(bubbleCount), (bubbles > 65535) ? 32'd65535 : 32'(bubbles));
      chk("bubbleCount_sat2", 32'(s_bubbleCount), (bubbles > 3) ? 32'd3 : 32'(bubbles));
   endtask

   // One clock: check combinational outputs, advance the model, check state.
   task automatic step();
      slot_t nxt;
      bit    lu;
      #1;
      lu = load_use_exp();
      chk("stallOut", 32'(stallOut), 32'((lu && !flush) || stallIn));
      nxt = m;
      if (reset) begin
         nxt = empty_slot();
         bubbles = 0;
      end else if (flush) begin
         nxt = empty_slot();
      end else if (stallIn) begin
         nxt = m;
      end else if (lu) begin
         nxt = empty_slot();
         bubbles++;
      end else begin
         nxt.v = idValid; nxt.ctrl = idValid ? idCtrl : 4'd0;
         nxt.rd = idRd; nxt.rs1 = idRs1; nxt.rs2 = idRs2;
         nxt.op = idAluOp; nxt.imm = idImm; nxt.src = idAluSrc;
         nxt.d1 = idData1; nxt.d2 = idData2;
      end
      @(posedge clk);
      #1;
      m = nxt;
      check_outputs();
   endtask

   task automatic set_id(input bit v, input bit [4:0] rs1, input bit [4:0] rs2,
                         input bit [4:0] rd, input bit [3:0] ctrl);
      idValid = v; idRs1 = rs1; idRs2 = rs2; idRd = rd; idCtrl = ctrl;
      idData1 = $urandom; idData2 = $urandom; idImm = $urandom;
      idAluOp = 4'($urandom); idAluSrc = 1'($urandom);
   endtask

   logic [31:0] snap_imm;
   logic [4:0]  snap_rd;
   logic [31:0] snap_d1;

   initial begin
      m = empty_slot();
      bubbles = 0;
      reset = 1; flush = 0; stallIn = 0;
      set_id(0, 0, 0, 0, 0);
      exMemRegWrite = 0; exMemRd = 0; exMemResult = 0;
      memWbRegWrite = 0; memWbRd = 0; memWbResult = 0;
      step();
      chk("rst_exValid", 32'(exValid), 32'd0);
      chk("rst_data1", data1, 32'd0);
      chk("rst_data2", data2, 32'd0);
      chk("rst_bubbleCount", 32'(bubbleCount), 32'd0);
      reset = 0;

      // valid add, then reset mid-operation
      set_id(1, 1, 2, 3, 4'b1000);
      idData1 = 32'h0000_1111;
      step();
      chk("add_loaded", 32'(exValid), 32'd1);
      reset = 1;
      step();
      chk("midrst_exValid", 32'(exValid), 32'd0);
      chk("midrst_exCtrl", 32'(exCtrl), 32'd0);
      chk("midrst_data1", data1, 32'd0);
      chk("midrst_bubbles", 32'(bubbleCount), 32'd0);
      reset = 0;

      // EX/MEM beats MEM/WB on the same index
      set_id(1, 5, 6, 9, 4'b1000);
      idData1 = 32'h5555_5555;
      step();
      exMemRegWrite = 1; exMemRd = 5; exMemResult = 32'hDEADBEEF;
      memWbRegWrite = 1; memWbRd = 5; memWbResult = 32'h0000_1234;
      #1 chk("fwd_exmem_priority", data1, 32'hDEADBEEF);
      exMemRd = 6;
      #1 chk("fwd_memwb", data1, 32'h0000_1234);

      // x0 never forwards
      set_id(1, 0, 0, 9, 4'b1000);
      idData1 = 32'd0;
      step();
      exMemRd = 0; exMemResult = 32'hFFFF_FFFF;
      memWbRd = 0;
      #1 chk("fwd_x0", data1, 32'd0);
      exMemRegWrite = 0; memWbRegWrite = 0;

      // load-use: lw x7 then consumer of x7 in rs2
      set_id(1, 1, 2, 7, 4'b1101);
      step();
      set_id(1, 3, 7, 8, 4'b1000);
      #1 chk("lu_stallOut", 32'(stallOut), 32'd1);
      step();
      chk("lu_bubble_valid", 32'(exValid), 32'd0);
      chk("lu_bubble_count", 32'(bubbleCount), 32'd1);
      step();
      chk("lu_after_valid", 32'(exValid), 32'd1);
      chk("lu_after_rd", 32'(exRd), 32'd8);

      // flush beats stall
      set_id(1, 1, 2, 4, 4'b1000);
      step();
      flush = 1; stallIn = 1;
      step();
      chk("flush_over_stall", 32'(exValid), 32'd0);
      flush = 0; stallIn = 0;

      // stall holds everything for 3 cycles
      set_id(1, 10, 11, 12, 4'b1001);
      step();
      snap_imm = imm; snap_rd = exRd; snap_d1 = data1;
      stallIn = 1;
      for (int i = 0; i < 3; i++) begin
         set_id(1, 13, 14, 15, 4'b1111);
         step();
         chk("stall_hold_imm", imm, snap_imm);
         chk("stall_hold_rd", 32'(exRd), 32'(snap_rd));
         chk("stall_hold_d1", data1, snap_d1);
      end
      stallIn = 0;

      // saturation: lw x7,0(x7) held in ID alternates load / bubble
      reset = 1;
      step();
      reset = 0;
      set_id(1, 7, 1, 7, 4'b1101);
      for (int i = 0; i < 9; i++) step();
      chk("sat2_count", 32'(s_bubbleCount), 32'd3);
      chk("sat16_count", 32'(bubbleCount), 32'd4);

      // randomized traffic over a small register window to provoke hazards
      for (int i = 0; i < 400; i++) begin
         reset   = ($urandom_range(0, 63) == 0);
         flush   = ($urandom_range(0, 9) == 0);
         stallIn = ($urandom_range(0, 7) == 0);
         set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 4'($urandom));
         exMemRegWrite = 1'($urandom); exMemRd = 5'($urandom_range(0, 7));
         exMemResult = $urandom;
         memWbRegWrite = 1'($urandom); memWbRd = 5'($urandom_range(0, 7));
         memWbResult = $urandom;
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
